ftdi_tx_wr_if: RTL and testbench
================================

# ftdi_tx_wr_if

Downstream stage of the loop-back byte generator. Accepts single-cycle byte strobes, buffers them in a small synchronous FIFO, and drains the FIFO onto an FT245-style asynchronous write port: wait for TXE# low, drive data, pulse WR#. It sits between on-chip byte sources and the FTDI chip pins, so bursty producers never have to see FTDI back-pressure.

## Interface
- DEPTH, 16: FIFO depth in bytes; must be a power of 2, at least 2.
- ADDR_W, 4: log2(DEPTH).
- WR_SETUP, 2: cycles data and OE are valid before WR# falls; at least 1.
- WR_PULSE, 3: cycles WR# is held low; at least 1.
- WR_HOLD, 4: cycles data is held after WR# rises; at least 3, to cover TXE# synchroniser latency.
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  8  byte to enqueue.
- data_in_pulse  in  1  one-cycle write strobe for data_in.
- ftdi_txe_n  in  1  FTDI TX-FIFO-not-ready, asynchronous; low means the FTDI can accept a byte.
- ftdi_wr_n  out  1  write strobe to the FTDI, active low.
- ftdi_data_o  out  8  data to the FTDI bus.
- ftdi_data_oe  out  1  bus output enable for the pad tri-state.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- fill_level  out  ADDR_W+1  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when a byte is dropped.
- overflow_sticky  out  1  set by any overflow; cleared only by reset.

## Operation
- Reset values:
  - ftdi_wr_n = 1, ftdi_data_o = 0, ftdi_data_oe = 0.
  - fifo_empty = 1, fifo_full = 0, fill_level = 0.
  - overflow = 0, overflow_sticky = 0.
  - FIFO pointers = 0; state = IDLE; txe synchroniser flops = 1.
- ftdi_txe_n goes through a 2-flop synchroniser to txe_s. Only txe_s is used.
- Push: when data_in_pulse = 1, write data_in at wr_ptr and increment wr_ptr, provided count < DEPTH or a pop occurs in the same cycle.
- Full without a same-cycle pop: the byte is dropped, overflow pulses for 1 cycle, overflow_sticky sets, and pointers are unchanged.
- Pop: happens only on the STROBE→HOLD transition; increments rd_ptr.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers are ADDR_W bits and wrap modulo DEPTH. Count is ADDR_W+1 bits.
- State machine:
  - IDLE: oe = 0, wr_n = 1. If count > 0 and txe_s = 0, register ftdi_data_o ← mem[rd_ptr], set oe = 1, and go to SETUP.
  - SETUP: hold for WR_SETUP cycles, then set wr_n = 0 and go to STROBE.
  - STROBE: hold wr_n low for WR_PULSE cycles. Then set wr_n = 1, pop, and go to HOLD.
  - HOLD: data and oe stay driven for WR_HOLD cycles, then go to IDLE. oe drops on entry to IDLE.
- A single phase counter, reloaded on each state entry, times SETUP, STROBE and HOLD.
- TXE# rising during SETUP or STROBE is ignored; the current transfer completes.
- Reset mid-transfer: wr_n returns high asynchronously, oe drops, and FIFO contents are discarded.

## Timing
- All outputs are registered.
- Per-byte throughput when TXE# stays low: 1 + WR_SETUP + WR_PULSE + WR_HOLD cycles, which is 10 with defaults.
- Latency, with data_in_pulse sampled at edge E0:
  - fill_level = 1 after E0.
  - IDLE decision at E1; ftdi_data_o and oe valid after E1.
  - wr_n low after E(1+WR_SETUP).
  - wr_n high and pop after E(1+WR_SETUP+WR_PULSE).
  - IDLE reached after E(1+WR_SETUP+WR_PULSE+WR_HOLD).
- TXE# path: a change on ftdi_txe_n is visible to IDLE 2 edges later.
- fifo_full, fifo_empty and fill_level reflect the count after the current edge.

## Structure
- ftdi_pkg: state encoding (IDLE, SETUP, STROBE, HOLD as 2-bit constants) and the default timing constants. The same package later serves the RX read interface.
- Sub-module ftdi_byte_fifo:
  - Contents: synchronous FIFO (mem, wr/rd pointers, count, full/empty, overflow).
  - Parameters: DEPTH, ADDR_W.
  - Ports: push/din, pop/dout.
- Top level: synchroniser, FSM, phase counter, output registers.

## Test plan
- Single byte, ftdi_txe_n held low, byte 0x30 pulsed at E0:
  - ftdi_data_o = 0x30 and oe = 1 after E1.
  - wr_n low after E3 through E6, back high after E6.
  - fill_level returns to 0 after E6.
  - oe = 0 after E10.
- Back-pressure, ftdi_txe_n high, bytes 0x30, 0x2D, 0x31 pushed:
  - fill_level = 3; wr_n stays 1.
  - Drop txe_n: three transfers in order 0x30, 0x2D, 0x31, spaced 10 cycles.
- Overflow, ftdi_txe_n high, 17 pushes of 0x41..0x51:
  - fifo_full after push 16.
  - Push 17 gives a 1-cycle overflow pulse and sets overflow_sticky.
  - Drain yields 0x41..0x50, and 0x51 is absent.
- Full with simultaneous push/pop: FIFO full, push 0x5A on the STROBE→HOLD cycle.
  - No overflow; fill_level stays 16; 0x5A is output last.
- Pointer wrap-around: 40 bytes streamed with txe_n low and producer every 12 cycles → output sequence identical to input, no overflow.
- Reset mid-STROBE: assert rst_n low while wr_n = 0.
  - wr_n = 1, oe = 0, fill_level = 0 immediately.
  - No transfer after release until a new push.

Source files
------------

// File: rtl/ftdi_pkg.sv
// Shared FTDI FT245 port definitions: FSM state encoding and default timing.
// Also used by the RX read interface.
package ftdi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ftdi_state_e;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_WR_SETUP = 2;
  localparam int DEF_WR_PULSE = 3;
  localparam int DEF_WR_HOLD  = 4;
  localparam int PH_W         = 4;

  function automatic logic [PH_W-1:0] ph_load(int n);
    return PH_W'(n - 1);
  endfunction

endpackage

// File: rtl/ftdi_tx_wr_if_if.sv
// FT245 write-side pin bundle.
// master = on-chip writer, slave = FTDI chip / pad model.
interface ftdi_tx_wr_if_if;
  logic       ftdi_txe_n;
  logic       ftdi_wr_n;
  logic [7:0] ftdi_data_o;
  logic       ftdi_data_oe;

  modport master (
    input  ftdi_txe_n,
    output ftdi_wr_n,
    output ftdi_data_o,
    output ftdi_data_oe
  );

  modport slave (
    output ftdi_txe_n,
    input  ftdi_wr_n,
    input  ftdi_data_o,
    input  ftdi_data_oe
  );
endinterface

// File: rtl/ftdi_byte_fifo.sv
// Synchronous byte FIFO with registered flags and overflow reporting.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module ftdi_byte_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            push,
  input  logic [7:0]      din,
  input  logic            pop,
  output logic [7:0]      dout,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            overflow_sticky
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt_nxt;
  logic              do_push;
  logic              do_pop;
  logic              drop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != CNT_MAX) || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = level;
    if (do_push && !do_pop)
      cnt_nxt = level + CNT_ONE;
    else if (!do_push && do_pop)
      cnt_nxt = level - CNT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      full            <= 1'b0;
      empty           <= 1'b1;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      level    <= cnt_nxt;
      full     <= (cnt_nxt == CNT_MAX);
      empty    <= (cnt_nxt == '0);
      overflow <= drop;
      if (drop)
        overflow_sticky <= 1'b1;
    end
  end

endmodule

// File: rtl/ftdi_tx_wr_if.sv
// Buffers byte strobes and drains them onto an FT245 asynchronous write port.
// One phase counter times SETUP/STROBE/HOLD; the pop happens as WR# rises.
module ftdi_tx_wr_if
  import ftdi_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WR_SETUP = DEF_WR_SETUP,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int WR_HOLD  = DEF_WR_HOLD
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [7:0]             data_in,
  input  logic                   data_in_pulse,
  ftdi_tx_wr_if_if.master        ftdi,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic [ADDR_W:0]        fill_level,
  output logic                   overflow,
  output logic                   overflow_sticky
);

  ftdi_state_e     state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic            txe_m, txe_s;
  logic            wr_n_q, wr_n_nxt;
  logic            oe_q, oe_nxt;
  logic [7:0]      data_q, data_nxt;
  logic [7:0]      fifo_dout;
  logic            pop;

  ftdi_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .push            (data_in_pulse),
    .din             (data_in),
    .pop             (pop),
    .dout            (fifo_dout),
    .full            (fifo_full),
    .empty           (fifo_empty),
    .level           (fill_level),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  assign ftdi.ftdi_wr_n    = wr_n_q;
  assign ftdi.ftdi_data_oe = oe_q;
  assign ftdi.ftdi_data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= ftdi.ftdi_txe_n;
      txe_s <= txe_m;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    wr_n_nxt  = wr_n_q;
    oe_nxt    = oe_q;
    data_nxt  = data_q;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        wr_n_nxt = 1'b1;
        oe_nxt   = 1'b0;
        if (!fifo_empty && !txe_s) begin
          data_nxt  = fifo_dout;
          oe_nxt    = 1'b1;
          state_nxt = SETUP;
          phase_nxt = ph_load(WR_SETUP);
        end
      end
      SETUP: begin
        if (phase == '0) begin
          wr_n_nxt  = 1'b0;
          state_nxt = STROBE;
          phase_nxt = ph_load(WR_PULSE);
        end else begin
          phase_nxt = phase - 1'b1;
        end
      end
      STROBE: begin
        if (phase == '0) begin
          wr_n_nxt  = 1'b1;
          pop       = 1'b1;
          state_nxt = HOLD;
          phase_nxt = ph_load(WR_HOLD);
        end else begin
          phase_nxt = phase - 1'b1;
        end
      end
      HOLD: begin
        if (phase == '0) begin
          oe_nxt    = 1'b0;
          state_nxt = IDLE;
        end else begin
          phase_nxt = phase - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      wr_n_q <= 1'b1;
      oe_q   <= 1'b0;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      wr_n_q <= wr_n_nxt;
      oe_q   <= oe_nxt;
      data_q <= data_nxt;
    end
  end

endmodule

// File: tb/tb_ftdi_tx_wr_if.sv
// Directed bench for ftdi_tx_wr_if.
// Bytes are captured on each WR# falling edge.
module tb_ftdi_tx_wr_if;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_pulse = 1'b0;
  logic       fifo_full, fifo_empty;
  logic [4:0] fill_level;
  logic       overflow, overflow_sticky;

  ftdi_tx_wr_if_if bus ();

  ftdi_tx_wr_if dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .data_in         (data_in),
    .data_in_pulse   (data_in_pulse),
    .ftdi            (bus),
    .fifo_full       (fifo_full),
    .fifo_empty      (fifo_empty),
    .fill_level      (fill_level),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clk_i = ~clk_i;

  int         nvec = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         ovf_cnt = 0;
  logic       prev_wr = 1'b1;
  logic [7:0] cap[$];
  int         cap_cyc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (prev_wr && !bus.ftdi_wr_n) begin
      cap.push_back(bus.ftdi_data_o);
      cap_cyc.push_back(cyc);
    end
    if (overflow)
      ovf_cnt = ovf_cnt + 1;
    prev_wr = bus.ftdi_wr_n;
  end

  task automatic chk(string tag, int unsigned obs, int unsigned exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(logic [7:0] b);
    data_in = b;
    data_in_pulse = 1'b1;
    tick();
    data_in_pulse = 1'b0;
  endtask

  task automatic wait_caps(int n, int lim);
    for (int i = 0; i < lim && cap.size() < n; i++) tick();
    chk("cap_count", cap.size(), n);
  endtask

  task automatic wait_wrlow(int lim);
    for (int i = 0; i < lim && bus.ftdi_wr_n; i++) tick();
    chk("wr_low_seen", bus.ftdi_wr_n, 0);
  endtask

  task automatic cmp_caps(string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size())
        chk(tag, cap[i], exp_q[i]);
      else
        chk(tag, 9'h100, exp_q[i]);
    end
  endtask

  task automatic clear_caps();
    cap.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.ftdi_txe_n = 1'b0;
    ticks(3);
    chk("rst_wr_n", bus.ftdi_wr_n, 1);
    chk("rst_data", bus.ftdi_data_o, 0);
    chk("rst_oe", bus.ftdi_data_oe, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sticky", overflow_sticky, 0);
    rst_n = 1'b1;
    ticks(4);

    // single byte, timing relative to push edge E0
    push(8'h30);
    chk("t1_fill_e0", fill_level, 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("t1_wr_n_e%0d", k), bus.ftdi_wr_n,
          (k >= 3 && k <= 5) ? 0 : 1);
      chk($sformatf("t1_oe_e%0d", k), bus.ftdi_data_oe,
          (k <= 9) ? 1 : 0);
      if (k == 1) chk("t1_data_e1", bus.ftdi_data_o, 8'h30);
      if (k == 5) chk("t1_fill_e5", fill_level, 1);
      if (k == 6) chk("t1_fill_e6", fill_level, 0);
    end
    ticks(3);

    // back-pressure then release
    clear_caps();
    bus.ftdi_txe_n = 1'b1;
    ticks(3);
    push(8'h30);
    push(8'h2D);
    push(8'h31);
    chk("t2_fill", fill_level, 3);
    ticks(6);
    chk("t2_wr_n_idle", bus.ftdi_wr_n, 1);
    chk("t2_no_xfer", cap.size(), 0);
    bus.ftdi_txe_n = 1'b0;
    wait_caps(3, 60);
    exp_q = '{8'h30, 8'h2D, 8'h31};
    cmp_caps("t2_data");
    if (cap_cyc.size() == 3) begin
      chk("t2_gap0", cap_cyc[1] - cap_cyc[0], 10);
      chk("t2_gap1", cap_cyc[2] - cap_cyc[1], 10);
    end
    ticks(12);
    chk("t2_empty", fifo_empty, 1);

    // overflow then full push/pop
    clear_caps();
    bus.ftdi_txe_n = 1'b1;
    ticks(3);
    for (int i = 0; i < 16; i++) push(8'(8'h41 + i));
    chk("t3_full", fifo_full, 1);
    chk("t3_fill16", fill_level, 16);
    chk("t3_no_ovf", overflow, 0);
    push(8'h51);
    chk("t3_ovf_pulse", overflow, 1);
    chk("t3_sticky", overflow_sticky, 1);
    chk("t3_fill_keep", fill_level, 16);
    tick();
    chk("t3_ovf_clr", overflow, 0);
    chk("t3_sticky_hold", overflow_sticky, 1);
    bus.ftdi_txe_n = 1'b0;
    wait_wrlow(20);
    ticks(2);
    push(8'h5A);
    chk("t4_no_ovf", overflow, 0);
    chk("t4_fill16", fill_level, 16);
    chk("t4_wr_n_up", bus.ftdi_wr_n, 1);
    wait_caps(17, 300);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h41 + i));
    exp_q.push_back(8'h5A);
    cmp_caps("t34_data");
    ticks(12);
    chk("t34_empty", fifo_empty, 1);

    // wrap-around stream
    clear_caps();
    ovf_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5));
      ticks(11);
    end
    wait_caps(40, 100);
    cmp_caps("t5_data");
    chk("t5_ovf_cnt", ovf_cnt, 0);

    // reset mid-STROBE
    ticks(12);
    push(8'h77);
    push(8'h78);
    wait_wrlow(20);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_n", bus.ftdi_wr_n, 1);
    chk("t6_oe", bus.ftdi_data_oe, 0);
    chk("t6_fill", fill_level, 0);
    chk("t6_sticky", overflow_sticky, 0);
    tick();
    rst_n = 1'b1;
    clear_caps();
    ticks(30);
    chk("t6_no_xfer", cap.size(), 0);
    chk("t6_empty", fifo_empty, 1);
    push(8'h55);
    wait_caps(1, 30);
    exp_q = '{8'h55};
    cmp_caps("t6_data");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
